// File: rtl/spi_target.sv
// SPI mode-0 peripheral with a UART-style byte-register port.
// SPI inputs are oversampled in the i_clk domain; all SPI actions happen on detected edges.
module spi_target #(
  parameter logic [7:0] IDLE_BYTE = 8'hFF
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_cs_n,
  input  logic       i_sclk,
  input  logic       i_copi,
  output logic       o_cipo,
  output logic       o_cipo_oe,
  input  logic       i_en,
  input  logic       i_wr,
  input  logic [3:0] i_addr,
  input  logic [7:0] i_data,
  output logic [7:0] o_data
);

  // [0],[1] form the synchronizer, [2] is the edge-detect history flop
  logic [2:0] cs_sync_q, sclk_sync_q, copi_sync_q;
  logic [1:0] warm_q;
  logic       armed_q, armed_d;
  logic       selected_q, selected_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] rx_shift_q, rx_shift_d;
  logic [7:0] rx_buf_q, rx_buf_d;
  logic       rx_rdy_q, rx_rdy_d;
  logic [7:0] tx_shift_q, tx_shift_d;
  logic [7:0] tx_hold_q, tx_hold_d;
  logic       tx_full_q, tx_full_d;
  logic       overrun_q, overrun_d;
  logic       abort_q, abort_d;
  logic [7:0] o_data_q, o_data_d;

  logic       cs_fall, cs_rise, sclk_rise, sclk_fall;
  logic       rd, rd_rx, rd_stat, wr_tx, reload;
  logic [7:0] rx_byte, rd_data;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cs_sync_q   <= 3'b111;
      sclk_sync_q <= 3'b000;
      copi_sync_q <= 3'b000;
      warm_q      <= 2'd0;
    end else begin
      cs_sync_q   <= {cs_sync_q[1:0], i_cs_n};
      sclk_sync_q <= {sclk_sync_q[1:0], i_sclk};
      copi_sync_q <= {copi_sync_q[1:0], i_copi};
      if (!warm_q[1]) warm_q <= warm_q + 2'd1;
    end
  end

  // A CS falling edge only counts once CS has been genuinely sampled high after reset,
  // so a CS held low through reset does not look like a fresh select.
  assign cs_fall   = armed_q & cs_sync_q[2] & ~cs_sync_q[1];
  assign cs_rise   = selected_q & ~cs_sync_q[2] & cs_sync_q[1];
  assign sclk_rise = selected_q & ~sclk_sync_q[2] & sclk_sync_q[1];
  assign sclk_fall = selected_q & sclk_sync_q[2] & ~sclk_sync_q[1];

  assign rd      = i_en & ~i_wr;
  assign rd_rx   = rd & (i_addr == 4'd3);
  assign rd_stat = rd & (i_addr == 4'd4);
  assign wr_tx   = i_en & i_wr & (i_addr == 4'd1) & ~tx_full_q;
  assign reload  = cs_fall | (sclk_fall & (bit_cnt_q == 3'd0));
  assign rx_byte = {rx_shift_q[6:0], copi_sync_q[1]};

  always_comb begin
    rd_data = 8'h00;
    case (i_addr)
      4'd0:    rd_data = {7'b0, ~tx_full_q};
      4'd2:    rd_data = {7'b0, rx_rdy_q};
      4'd3:    rd_data = rx_buf_q;
      4'd4:    rd_data = {5'b0, overrun_q, abort_q, selected_q};
      default: rd_data = 8'h00;
    endcase
  end

  always_comb begin
    armed_d    = armed_q | (warm_q[1] & cs_sync_q[1]);
    selected_d = selected_q;
    bit_cnt_d  = bit_cnt_q;
    rx_shift_d = rx_shift_q;
    rx_buf_d   = rx_buf_q;
    rx_rdy_d   = rx_rdy_q;
    tx_shift_d = tx_shift_q;
    tx_hold_d  = tx_hold_q;
    tx_full_d  = tx_full_q;
    overrun_d  = overrun_q;
    abort_d    = abort_q;
    o_data_d   = rd ? rd_data : o_data_q;

    // Clear-on-read first so same-cycle SPI events below take priority
    if (rd_rx) rx_rdy_d = 1'b0;
    if (rd_stat) begin
      overrun_d = 1'b0;
      abort_d   = 1'b0;
    end

    if (cs_fall) begin
      selected_d = 1'b1;
      bit_cnt_d  = 3'd0;
    end
    if (cs_rise) begin
      selected_d = 1'b0;
      bit_cnt_d  = 3'd0;
      if (bit_cnt_q != 3'd0) abort_d = 1'b1;
    end

    if (sclk_rise) begin
      rx_shift_d = rx_byte;
      bit_cnt_d  = bit_cnt_q + 3'd1;
      if (bit_cnt_q == 3'd7) begin
        rx_buf_d = rx_byte;
        rx_rdy_d = 1'b1;
        if (rx_rdy_q && !rd_rx) overrun_d = 1'b1;
      end
    end

    if (sclk_fall && bit_cnt_q != 3'd0) tx_shift_d = {tx_shift_q[6:0], 1'b1};
    if (reload) begin
      tx_shift_d = tx_full_q ? tx_hold_q : IDLE_BYTE;
      tx_full_d  = 1'b0;
    end
    // A write racing a reload lands after it: reload already used the old holding state
    if (wr_tx) begin
      tx_hold_d = i_data;
      tx_full_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      armed_q    <= 1'b0;
      selected_q <= 1'b0;
      bit_cnt_q  <= 3'd0;
      rx_shift_q <= 8'h00;
      rx_buf_q   <= 8'h00;
      rx_rdy_q   <= 1'b0;
      tx_shift_q <= IDLE_BYTE;
      tx_hold_q  <= 8'h00;
      tx_full_q  <= 1'b0;
      overrun_q  <= 1'b0;
      abort_q    <= 1'b0;
      o_data_q   <= 8'h00;
    end else begin
      armed_q    <= armed_d;
      selected_q <= selected_d;
      bit_cnt_q  <= bit_cnt_d;
      rx_shift_q <= rx_shift_d;
      rx_buf_q   <= rx_buf_d;
      rx_rdy_q   <= rx_rdy_d;
      tx_shift_q <= tx_shift_d;
      tx_hold_q  <= tx_hold_d;
      tx_full_q  <= tx_full_d;
      overrun_q  <= overrun_d;
      abort_q    <= abort_d;
      o_data_q   <= o_data_d;
    end
  end

  assign o_cipo    = selected_q ? tx_shift_q[7] : 1'b1;
  assign o_cipo_oe = selected_q;
  assign o_data    = o_data_q;

endmodule

// File: tb/tb_spi_target.sv
// Self-checking bench for spi_target: acts as SPI initiator at f_clk/8 and as register-port CPU.
`timescale 1ns/1ps
module tb_spi_target;

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic       i_cs_n = 1'b1;
  logic       i_sclk = 1'b0;
  logic       i_copi = 1'b0;
  logic       o_cipo, o_cipo_oe;
  logic       i_en = 1'b0;
  logic       i_wr = 1'b0;
  logic [3:0] i_addr = 4'd0;
  logic [7:0] i_data = 8'h00;
  logic [7:0] o_data;

  int checks = 0;
  int failures = 0;

  // Scoreboards: bytes the DUT should deliver on RX_DAT, and bytes the initiator should see on CIPO
  logic [7:0] exp_rx[$];
  logic [7:0] exp_cipo[$];
  bit         rx_pend = 1'b0;

  always #5 i_clk = ~i_clk;

  spi_target dut (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_cs_n    (i_cs_n),
    .i_sclk    (i_sclk),
    .i_copi    (i_copi),
    .o_cipo    (o_cipo),
    .o_cipo_oe (o_cipo_oe),
    .i_en      (i_en),
    .i_wr      (i_wr),
    .i_addr    (i_addr),
    .i_data    (i_data),
    .o_data    (o_data)
  );

  task automatic reg_write(input logic [3:0] a, input logic [7:0] d);
    @(posedge i_clk); #1;
    i_en = 1'b1; i_wr = 1'b1; i_addr = a; i_data = d;
    @(posedge i_clk); #1;
    i_en = 1'b0; i_wr = 1'b0;
  endtask

  task automatic reg_read(input logic [3:0] a, output logic [7:0] d);
    @(posedge i_clk); #1;
    i_en = 1'b1; i_wr = 1'b0; i_addr = a;
    @(posedge i_clk); #1;
    i_en = 1'b0;
    d = o_data;
  endtask

  task automatic cs_low();
    i_cs_n = 1'b0;
    #40;
  endtask

  task automatic cs_high();
    #40;
    i_cs_n = 1'b1;
    #60;
  endtask

  // Half-period of 40 ns = 4 i_clk; initiator samples CIPO at each SCLK rise
  task automatic spi_bits(input logic [7:0] d, input int n, output logic [7:0] got);
    got = 8'h00;
    for (int i = 0; i < n; i++) begin
      i_copi = d[7-i];
      #40;
      got = {got[6:0], o_cipo};
      i_sclk = 1'b1;
      #40;
      i_sclk = 1'b0;
    end
  endtask

  task automatic spi_byte(input logic [7:0] d);
    logic [7:0] got, exp;
    if (rx_pend) void'(exp_rx.pop_back());
    exp_rx.push_back(d);
    rx_pend = 1'b1;
    spi_bits(d, 8, got);
    checks++;
    if (exp_cipo.size() == 0) begin
      failures++;
      $display("FAIL cipo_byte: got %h, no byte expected", got);
    end else begin
      exp = exp_cipo.pop_front();
      if (got !== exp) begin
        failures++;
        $display("FAIL cipo_byte: got %h expected %h", got, exp);
      end
    end
  endtask

  task automatic read_rx();
    logic [7:0] d, exp;
    reg_read(4'd3, d);
    rx_pend = 1'b0;
    checks++;
    if (exp_rx.size() == 0) begin
      failures++;
      $display("FAIL rx_dat: got %h, no byte expected", d);
    end else begin
      exp = exp_rx.pop_front();
      if (d !== exp) begin
        failures++;
        $display("FAIL rx_dat: got %h expected %h", d, exp);
      end
    end
  endtask

  task automatic test_reset();
    logic [7:0] d;
    checks++;
    if (o_cipo !== 1'b1 || o_cipo_oe !== 1'b0 || o_data !== 8'h00) begin
      failures++;
      $display("FAIL reset_pins: cipo=%b oe=%b data=%h expected 1 0 00", o_cipo, o_cipo_oe, o_data);
    end
    reg_read(4'd0, d);
    checks++;
    if (d !== 8'h01) begin failures++; $display("FAIL reset_tx_rdy: got %h expected 01", d); end
    reg_read(4'd2, d);
    checks++;
    if (d !== 8'h00) begin failures++; $display("FAIL reset_rx_rdy: got %h expected 00", d); end
    reg_read(4'd4, d);
    checks++;
    if (d !== 8'h00) begin failures++; $display("FAIL reset_status: got %h expected 00", d); end
    reg_read(4'd9, d);
    checks++;
    if (d !== 8'h00) begin failures++; $display("FAIL unmapped_read: got %h expected 00", d); end
  endtask

  task automatic test_rx_basic();
    logic [7:0] d;
    cs_low();
    checks++;
    if (o_cipo_oe !== 1'b1) begin failures++; $display("FAIL oe_selected: got %b expected 1", o_cipo_oe); end
    exp_cipo.push_back(8'hFF);
    spi_byte(8'hA5);
    cs_high();
    checks++;
    if (o_cipo_oe !== 1'b0 || o_cipo !== 1'b1) begin
      failures++;
      $display("FAIL deselect_pins: oe=%b cipo=%b expected 0 1", o_cipo_oe, o_cipo);
    end
    reg_read(4'd2, d);
    checks++;
    if (d !== 8'h01) begin failures++; $display("FAIL rx_rdy_set: got %h expected 01", d); end
    read_rx();
    reg_read(4'd2, d);
    checks++;
    if (d !== 8'h00) begin failures++; $display("FAIL rx_rdy_clear: got %h expected 00", d); end
  endtask

  task automatic test_tx_reply();
    logic [7:0] d;
    reg_write(4'd1, 8'h3C);
    reg_write(4'd1, 8'h55);  // ignored: holding register already full
    reg_read(4'd0, d);
    checks++;
    if (d !== 8'h00) begin failures++; $display("FAIL tx_rdy_full: got %h expected 00", d); end
    cs_low();
    reg_read(4'd0, d);
    checks++;
    if (d !== 8'h01) begin failures++; $display("FAIL tx_rdy_loaded: got %h expected 01", d); end
    exp_cipo.push_back(8'h3C);
    spi_byte(8'h01);
    #40;
    read_rx();
    exp_cipo.push_back(8'hFF);
    spi_byte(8'h02);
    cs_high();
    read_rx();
  endtask

  task automatic test_overrun();
    logic [7:0] d;
    cs_low();
    exp_cipo.push_back(8'hFF);
    spi_byte(8'h11);
    exp_cipo.push_back(8'hFF);
    spi_byte(8'h22);
    #40;
    reg_read(4'd4, d);
    checks++;
    if (d !== 8'h05) begin failures++; $display("FAIL status_overrun: got %h expected 05", d); end
    reg_read(4'd4, d);
    checks++;
    if (d !== 8'h01) begin failures++; $display("FAIL status_cleared: got %h expected 01", d); end
    read_rx();
    cs_high();
  endtask

  task automatic test_abort();
    logic [7:0] d, got;
    cs_low();
    spi_bits(8'hB6, 5, got);
    cs_high();
    reg_read(4'd2, d);
    checks++;
    if (d !== 8'h00) begin failures++; $display("FAIL abort_no_rx: got %h expected 00", d); end
    reg_read(4'd4, d);
    checks++;
    if (d !== 8'h02) begin failures++; $display("FAIL status_abort: got %h expected 02", d); end
    reg_read(4'd4, d);
    checks++;
    if (d !== 8'h00) begin failures++; $display("FAIL abort_cleared: got %h expected 00", d); end
    cs_low();
    exp_cipo.push_back(8'hFF);
    spi_byte(8'h7E);
    cs_high();
    read_rx();
  endtask

  task automatic test_reset_mid();
    logic [7:0] d, got;
    reg_write(4'd1, 8'hAA);
    reg_read(4'd2, d);
    reg_read(4'd0, d);  // leaves o_data nonzero? TX_RDY=0 here, so read RX_RDY path below
    reg_read(4'd4, d);
    cs_low();
    reg_read(4'd4, d);  // o_data = 01 (selected) before reset
    spi_bits(8'h5A, 3, got);
    i_rst_n = 1'b0;
    #30;
    checks++;
    if (o_cipo !== 1'b1 || o_cipo_oe !== 1'b0 || o_data !== 8'h00) begin
      failures++;
      $display("FAIL reset_mid_pins: cipo=%b oe=%b data=%h expected 1 0 00", o_cipo, o_cipo_oe, o_data);
    end
    exp_rx.delete();
    exp_cipo.delete();
    rx_pend = 1'b0;
    i_rst_n = 1'b1;
    #80;
    checks++;
    if (o_cipo_oe !== 1'b0) begin failures++; $display("FAIL reset_no_reselect: got %b expected 0", o_cipo_oe); end
    reg_read(4'd0, d);
    checks++;
    if (d !== 8'h01) begin failures++; $display("FAIL reset_mid_tx_rdy: got %h expected 01", d); end
    reg_read(4'd4, d);
    checks++;
    if (d !== 8'h00) begin failures++; $display("FAIL reset_mid_status: got %h expected 00", d); end
    i_cs_n = 1'b1;
    #80;
    cs_low();
    exp_cipo.push_back(8'hFF);
    spi_byte(8'hC3);
    cs_high();
    reg_read(4'd4, d);
    checks++;
    if (d !== 8'h00) begin failures++; $display("FAIL after_reset_status: got %h expected 00", d); end
    read_rx();
  endtask

  initial begin
    #23;
    i_rst_n = 1'b1;
    #20;
    test_reset();
    test_rx_basic();
    test_tx_reply();
    test_overrun();
    test_abort();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/spi_target.md
# spi_target

SPI mode-0 responder that lets the design act as the peripheral end of an SPI link. It is the counterpart of the flash controller's initiator side. It oversamples CS/SCLK/COPI in the system clock domain, shifts bytes in and out MSB-first, and exposes a byte-register port identical in shape to the UART device. A CPU or test state machine can therefore poll/read received bytes and queue reply bytes.

## Interface
- IDLE_BYTE, 8'hFF, byte shifted out when no reply byte is queued
- i_clk  in  1  system clock (≥ 8× SCLK)
- i_rst_n  in  1  asynchronous active-low reset
- i_cs_n  in  1  SPI chip select, active low (async to i_clk)
- i_sclk  in  1  SPI clock from initiator, idle low (async)
- i_copi  in  1  controller-out data (async)
- o_cipo  out  1  controller-in data
- o_cipo_oe  out  1  output enable for CIPO pad (1 only while selected)
- i_en  in  1  register access strobe
- i_wr  in  1  1 = write, 0 = read (qualified by i_en)
- i_addr  in  4  register select
- i_data  in  8  write data
- o_data  out  8  read data, registered

## Operation
- Register map:
  - 0 TX_RDY: read 1 when the reply holding register is empty.
  - 1 TX_DAT: write loads the holding register and clears TX_RDY. Ignored if TX_RDY=0.
  - 2 RX_RDY: read 1 when a received byte is pending.
  - 3 RX_DAT: read returns the byte and clears RX_RDY.
  - 4 STATUS: read {5'b0, overrun, abort, selected}. The read clears overrun and abort.
  - Other addresses read 8'h00. Writes to any address other than 1 are ignored.
- Input conditioning:
  - i_cs_n, i_sclk and i_copi each pass a 2-FF synchronizer.
  - A third flop per signal gives edge detect.
  - All SPI actions occur on detected edges, in i_clk.
- Select (CS falling):
  - Bit counter cleared; selected=1; o_cipo_oe=1.
  - tx_shift loads the holding byte, or IDLE_BYTE if TX_RDY=1. The holding register is then marked empty (TX_RDY=1).
- SCLK rising:
  - rx_shift <= {rx_shift[6:0], copi}; counter increments mod 8.
  - When the counter wraps (8th bit), the byte goes to the rx buffer and RX_RDY=1.
  - If RX_RDY was already 1, the buffer is overwritten and overrun=1.
- SCLK falling:
  - If the counter is 0 (byte boundary, after ≥1 byte), reload tx_shift as on select.
  - Otherwise shift tx_shift left.
- o_cipo = tx_shift[7] while selected; 1 while deselected.
- Deselect (CS rising):
  - o_cipo_oe=0; selected=0.
  - If the counter ≠ 0, the partial byte is discarded (no RX_RDY) and abort=1.
  - Counter cleared.
  - A holding byte written but not yet loaded stays queued.
- SCLK edges while deselected are ignored.
- Simultaneous events:
  - Byte capture in the same cycle as an RX_DAT read: the read returns the old byte, the new byte is stored, and RX_RDY stays 1 (no overrun).
  - TX_DAT write in the same cycle as a reload: the reload uses the old state (IDLE_BYTE if empty), and the write is accepted afterwards.
- Reset values:
  - o_data=0, o_cipo=1, o_cipo_oe=0.
  - RX_RDY=0, TX_RDY=1, overrun=abort=selected=0, counter=0.
  - Synchronizers preset to cs_n=1, sclk=0.
- Reset asserted mid-transfer aborts immediately with no flags set. After release, the block waits for a fresh CS falling edge.

## Timing
- Register read: o_data is valid on the cycle after i_en && !i_wr and holds until the next read. Clear-on-read side effects take effect on that same edge.
- Register write: takes effect on the i_en edge. A TX_RDY read in the next cycle returns 0.
- SPI edge to internal action: 3 i_clk cycles.
- o_cipo changes at most 4 i_clk after an SCLK fall. This sets the constraints:
  - SCLK half-period ≥ 4 i_clk (max SCLK = f_clk/8).
  - CS setup to first SCLK rise ≥ 4 i_clk.
- RX_RDY is set 3 i_clk after the 8th SCLK rise.
- Reply byte deadline: a TX_DAT write must occur ≥1 i_clk before the byte-boundary reload, otherwise IDLE_BYTE is sent.

## Test plan
- Reset, no SPI activity -> o_cipo=1, o_cipo_oe=0, TX_RDY read 1, RX_RDY read 0, STATUS 8'h00.
- CS low, initiator shifts 8'hA5 at f_clk/8 -> RX_RDY=1; RX_DAT read 8'hA5; next RX_RDY read 0. CIPO bits seen by the initiator = 8'hFF.
- Write TX_DAT=8'h3C, then a 2-byte transfer sending 8'h01, 8'h02 -> initiator receives 8'h3C then 8'hFF. RX reads return 8'h01 (read between bytes) then 8'h02.
- Two bytes 8'h11, 8'h22 with no RX read between -> RX_DAT=8'h22. STATUS=8'h05 (overrun, selected) while CS low; the next STATUS read shows the overrun bit cleared.
- CS raised after 5 bits -> no RX_RDY; STATUS read 8'h02 then 8'h00. The next full byte 8'h7E is received correctly.
- i_rst_n pulsed low after 3 bits -> all outputs return to reset values. A following complete byte 8'hC3 on a fresh CS is received exactly.
